// File: rtl/pc_sequencer.sv
// Program counter / sequencer for the flow-control instruction memory.
// Supports absolute jumps, internal delay counting, a hardware loop stack and sticky stack errors.
module pc_sequencer #(
  parameter int unsigned    AW         = 8,
  parameter int unsigned    CW         = 32,
  parameter int unsigned    LCW        = 8,
  parameter int unsigned    LOOP_DEPTH = 4,
  parameter logic [AW-1:0]  RST_ADDR   = '0,
  parameter logic [AW-1:0]  START_ADDR = AW'(2)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           pchalt,
  input  logic           stop_req,
  input  logic           jump_req,
  input  logic [AW-1:0]  jump_addr,
  input  logic           delay_req,
  input  logic [CW-1:0]  delay_val,
  input  logic           loop_push,
  input  logic [LCW-1:0] loop_cnt,
  input  logic           loop_end,
  output logic [AW-1:0]  pcout,
  output logic           running,
  output logic           in_delay,
  output logic           count_done,
  output logic           stack_ovf,
  output logic           stack_unf
);

  localparam int unsigned SPW = $clog2(LOOP_DEPTH + 1);
  localparam int unsigned IW  = (LOOP_DEPTH > 1) ? $clog2(LOOP_DEPTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDelay} state_e;

  state_e         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic [AW-1:0]  stk_addr_q [LOOP_DEPTH];
  logic [AW-1:0]  stk_addr_d [LOOP_DEPTH];
  logic [LCW-1:0] stk_cnt_q  [LOOP_DEPTH];
  logic [LCW-1:0] stk_cnt_d  [LOOP_DEPTH];
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic           done_q, done_d;

  logic [AW-1:0]  pc_inc;
  logic [IW-1:0]  top_idx;
  logic [IW-1:0]  push_idx;
  logic           stk_empty;
  logic           stk_full;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    sp_d       = sp_q;
    stk_addr_d = stk_addr_q;
    stk_cnt_d  = stk_cnt_q;
    ovf_d      = ovf_q;
    unf_d      = unf_q;
    done_d     = 1'b0;
    pc_inc     = pc_q + 1'b1;
    top_idx    = IW'(sp_q - 1'b1);
    push_idx   = IW'(sp_q);
    stk_empty  = (sp_q == '0);
    stk_full   = (sp_q == SPW'(LOOP_DEPTH));

    // A halted cycle drops every strobe and leaves all state untouched.
    if (!pchalt) begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            pc_d    = START_ADDR;
            state_d = StRun;
          end
        end
        StRun: begin
          if (stop_req) begin
            state_d = StIdle;
          end else if (jump_req) begin
            pc_d = jump_addr;
          end else if (loop_end) begin
            if (stk_empty) begin
              unf_d = 1'b1;
              pc_d  = pc_inc;
            end else if (stk_cnt_q[top_idx] == '0) begin
              sp_d = sp_q - 1'b1;
              pc_d = pc_inc;
            end else begin
              stk_cnt_d[top_idx] = stk_cnt_q[top_idx] - 1'b1;
              pc_d               = stk_addr_q[top_idx];
            end
          end else if (loop_push) begin
            pc_d = pc_inc;
            if (stk_full) begin
              ovf_d = 1'b1;
            end else begin
              stk_addr_d[push_idx] = pc_inc;
              stk_cnt_d[push_idx]  = loop_cnt;
              sp_d                 = sp_q + 1'b1;
            end
          end else if (delay_req) begin
            if (delay_val < CW'(2)) begin
              pc_d   = pc_inc;
              done_d = 1'b1;
            end else begin
              // Request cycle plus DELAY cycles down to zero give delay_val cycles of hold.
              cnt_d   = delay_val - CW'(2);
              state_d = StDelay;
            end
          end else begin
            pc_d = pc_inc;
          end
        end
        StDelay: begin
          if (stop_req) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else if (cnt_q == '0) begin
            pc_d    = pc_inc;
            done_d  = 1'b1;
            state_d = StRun;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= RST_ADDR;
      cnt_q   <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < int'(LOOP_DEPTH); i++) begin
        stk_addr_q[i] <= '0;
        stk_cnt_q[i]  <= '0;
      end
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
      sp_q       <= sp_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      done_q     <= done_d;
      stk_addr_q <= stk_addr_d;
      stk_cnt_q  <= stk_cnt_d;
    end
  end

  assign pcout      = pc_q;
  assign running    = (state_q != StIdle);
  assign in_delay   = (state_q == StDelay);
  assign count_done = done_q;
  assign stack_ovf  = ovf_q;
  assign stack_unf  = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: a behavioural model predicts each cycle's outputs,
// a separate monitor compares them against the DUT.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        pchalt = 1'b0;
  logic        stop_req = 1'b0;
  logic        jump_req = 1'b0;
  logic [7:0]  jump_addr = '0;
  logic        delay_req = 1'b0;
  logic [31:0] delay_val = '0;
  logic        loop_push = 1'b0;
  logic [7:0]  loop_cnt = '0;
  logic        loop_end = 1'b0;
  logic [7:0]  pcout;
  logic        running, in_delay, count_done, stack_ovf, stack_unf;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .pchalt     (pchalt),
    .stop_req   (stop_req),
    .jump_req   (jump_req),
    .jump_addr  (jump_addr),
    .delay_req  (delay_req),
    .delay_val  (delay_val),
    .loop_push  (loop_push),
    .loop_cnt   (loop_cnt),
    .loop_end   (loop_end),
    .pcout      (pcout),
    .running    (running),
    .in_delay   (in_delay),
    .count_done (count_done),
    .stack_ovf  (stack_ovf),
    .stack_unf  (stack_unf)
  );

  typedef struct packed {
    logic [7:0] pc;
    logic       run;
    logic       dly;
    logic       done;
    logic       ovf;
    logic       unf;
  } exp_t;

  typedef struct {
    logic [7:0] addr;
    int         reps;
  } loop_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model: mode 0 idle, 1 running, 2 holding for a delay.
  int         m_mode = 0;
  logic [7:0] m_pc = 8'h00;
  int         m_hold = 0;
  loop_t      m_stack[$];
  logic       m_ovf = 1'b0;
  logic       m_unf = 1'b0;
  logic       m_done = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, want);
    end
  endtask

  task automatic model_step();
    loop_t e;
    m_done = 1'b0;
    if (rst) begin
      m_mode = 0;
      m_pc   = 8'h00;
      m_hold = 0;
      m_stack.delete();
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else if (!pchalt) begin
      if (m_mode == 0) begin
        if (start) begin
          m_pc   = 8'h02;
          m_mode = 1;
        end
      end else if (m_mode == 1) begin
        if (stop_req) m_mode = 0;
        else if (jump_req) m_pc = jump_addr;
        else if (loop_end) begin
          if (m_stack.size() == 0) begin
            m_unf = 1'b1;
            m_pc  = m_pc + 8'd1;
          end else if (m_stack[m_stack.size()-1].reps == 0) begin
            void'(m_stack.pop_back());
            m_pc = m_pc + 8'd1;
          end else begin
            m_stack[m_stack.size()-1].reps = m_stack[m_stack.size()-1].reps - 1;
            m_pc = m_stack[m_stack.size()-1].addr;
          end
        end else if (loop_push) begin
          if (m_stack.size() == 4) m_ovf = 1'b1;
          else begin
            e.addr = m_pc + 8'd1;
            e.reps = int'(loop_cnt);
            m_stack.push_back(e);
          end
          m_pc = m_pc + 8'd1;
        end else if (delay_req) begin
          if (delay_val < 2) begin
            m_pc   = m_pc + 8'd1;
            m_done = 1'b1;
          end else begin
            // Address is already shown in the request cycle; N-1 more held cycles follow.
            m_hold = int'(delay_val) - 1;
            m_mode = 2;
          end
        end else m_pc = m_pc + 8'd1;
      end else begin
        if (stop_req) m_mode = 0;
        else if (m_hold == 1) begin
          m_pc   = m_pc + 8'd1;
          m_done = 1'b1;
          m_mode = 1;
        end else m_hold = m_hold - 1;
      end
    end
    exp_q.push_back('{pc: m_pc, run: (m_mode != 0), dly: (m_mode == 2), done: m_done,
                      ovf: m_ovf, unf: m_unf});
  endtask

  // Called at a negedge with inputs set; predicts the next edge and advances one cycle.
  task automatic tick();
    model_step();
    @(negedge clk);
    start     = 1'b0;
    stop_req  = 1'b0;
    jump_req  = 1'b0;
    delay_req = 1'b0;
    loop_push = 1'b0;
    loop_end  = 1'b0;
  endtask

  task automatic do_reset_start();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    start = 1'b1;
    tick();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("pcout", 32'(pcout), 32'(e.pc));
        chk("running", 32'(running), 32'(e.run));
        chk("in_delay", 32'(in_delay), 32'(e.dly));
        chk("count_done", 32'(count_done), 32'(e.done));
        chk("stack_ovf", 32'(stack_ovf), 32'(e.ovf));
        chk("stack_unf", 32'(stack_unf), 32'(e.unf));
      end
    end
  end

  initial begin : watchdog
    #1ms;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin : driver
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    start = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();

    do_reset_start();
    tick();
    tick();
    delay_req = 1'b1;
    delay_val = 32'd5;
    tick();
    for (int i = 0; i < 7; i++) tick();

    do_reset_start();
    tick();
    loop_push = 1'b1;
    loop_cnt  = 8'd2;
    tick();
    for (int i = 0; i < 14; i++) begin
      if (m_pc == 8'd6 && i < 12) loop_end = 1'b1;
      tick();
    end

    do_reset_start();
    for (int i = 0; i < 5; i++) begin
      loop_push = 1'b1;
      loop_cnt  = 8'd0;
      tick();
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      loop_end = 1'b1;
      tick();
    end

    do_reset_start();
    delay_req = 1'b1;
    delay_val = 32'd8;
    tick();
    tick();
    tick();
    pchalt = 1'b1;
    for (int i = 0; i < 10; i++) begin
      start = (i == 4);
      tick();
    end
    pchalt = 1'b0;
    for (int i = 0; i < 10; i++) tick();

    jump_req  = 1'b1;
    jump_addr = 8'hFF;
    tick();
    tick();
    tick();
    delay_req = 1'b1;
    delay_val = 32'd20;
    tick();
    for (int i = 0; i < 3; i++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();

    for (int i = 0; i < 3000; i++) begin
      rst       = ($urandom_range(0, 299) == 0);
      pchalt    = ($urandom_range(0, 7) == 0);
      start     = ($urandom_range(0, 9) == 0);
      stop_req  = ($urandom_range(0, 59) == 0);
      jump_req  = ($urandom_range(0, 24) == 0);
      jump_addr = 8'($urandom);
      loop_end  = ($urandom_range(0, 7) == 0);
      loop_push = ($urandom_range(0, 7) == 0);
      loop_cnt  = 8'($urandom_range(0, 3));
      delay_req = ($urandom_range(0, 11) == 0);
      delay_val = 32'($urandom_range(0, 12));
      tick();
    end
    rst    = 1'b0;
    pchalt = 1'b0;
    tick();

    @(posedge clk);
    #2;
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
